// File: rtl/sram_req_port_pkg.sv
// ============================================================================
// sram_req_port_pkg
// Shared state encodings and credit-count sizing for the SRAM request port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_req_port_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } port_state_e;

    // Width able to hold every value 0..depth inclusive.
    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
// ============================================================================
// sram_rsp_fifo
// Synchronous response FIFO with push/pop, occupancy count and registered head.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rsp_fifo
    import sram_req_port_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RSP_DEPTH = 4,
    parameter int CW        = credit_width(RSP_DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_data_i,
    input  logic            pop_i,
    output logic [CW-1:0]   cnt_o,
    output logic [XLEN-1:0] head_o,
    output logic            not_empty_o
);

    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [XLEN-1:0] mem_q [RSP_DEPTH];
    logic [XLEN-1:0] mem_d [RSP_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            w_pop;

    // Pointers wrap modulo RSP_DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop = pop_i & (cnt_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, w_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign head_o      = mem_q[rd_ptr_q];
    assign not_empty_o = (cnt_q != '0);

    // Upstream credit accounting guarantees room for every push.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        push_i |-> (cnt_q < CW'(RSP_DEPTH)));

endmodule

`default_nettype wire

// File: rtl/sram_req_port.sv
// ============================================================================
// sram_req_port
// Valid/ready front end for a 1-cycle single-port SRAM with credit-checked
// response FIFO. Optional post-reset clear sweep: define SRAM_PORT_INIT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_req_port
    import sram_req_port_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int N_ENTRIES = 1024,
    parameter int RSP_DEPTH = 4,
    parameter int AW        = $clog2(N_ENTRIES)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [XLEN-1:0] req_data_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            sram_en_o,
    output logic            sram_we_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [XLEN-1:0] sram_wdata_o,
    input  logic [XLEN-1:0] sram_rdata_i,
    input  logic            flush_i,
    output logic            init_done_o
);

    localparam int CW = credit_width(RSP_DEPTH);

    logic          rd_pend_q, rd_pend_d;
    logic [CW-1:0] fifo_cnt;
    logic [CW:0]   credits_used;
    logic          run;
    logic          accept;

    // A read in flight already owns a FIFO slot, so it counts against credit.
    assign credits_used = {1'b0, fifo_cnt} + {{CW{1'b0}}, rd_pend_q};
    assign req_ready_o  = run & (credits_used < (CW + 1)'(RSP_DEPTH));
    assign accept       = req_valid_i & req_ready_o;

    always_comb begin
        rd_pend_d = accept & ~req_we_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= rd_pend_d;
        end
    end

    sram_rsp_fifo #(
        .XLEN      (XLEN),
        .RSP_DEPTH (RSP_DEPTH),
        .CW        (CW)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rd_pend_q),
        .push_data_i (sram_rdata_i),
        .pop_i       (rsp_ready_i),
        .cnt_o       (fifo_cnt),
        .head_o      (rsp_data_o),
        .not_empty_o (rsp_valid_o)
    );

`ifdef SRAM_PORT_INIT_EN
    port_state_e   state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        sram_en_o    = accept;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_data_i;
        case (state_q)
            S_INIT: begin
                sram_en_o    = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = sweep_q;
                sram_wdata_o = '0;
                sweep_d      = sweep_q + 1'b1;
                if (sweep_q == AW'(N_ENTRIES - 1)) begin
                    state_d = S_RUN;
                    sweep_d = '0;
                end
            end
            S_RUN: begin
                // Wait for the in-flight read to land before clearing the array.
                if (flush_i && !rd_pend_q) begin
                    state_d = S_INIT;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    assign run         = (state_q == S_RUN);
    assign init_done_o = run;
`else
    logic init_done_q, init_done_d;
    logic unused_flush;

    assign unused_flush = flush_i;

    always_comb begin
        init_done_d  = 1'b1;
        sram_en_o    = accept;
        sram_we_o    = req_we_i;
        sram_addr_o  = req_addr_i;
        sram_wdata_o = req_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= init_done_d;
        end
    end

    assign run         = init_done_q;
    assign init_done_o = init_done_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_req_port.sv
// ============================================================================
// tb_sram_req_port
// Self-checking bench: SRAM behavioural model plus an in-order response model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_req_port;

    localparam int XLEN      = 32;
    localparam int N_ENTRIES = 16;
    localparam int RSP_DEPTH = 4;
    localparam int AW        = 4;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic            req_we_i = 1'b0;
    logic [AW-1:0]   req_addr_i = '0;
    logic [XLEN-1:0] req_data_i = '0;
    logic            rsp_valid_o;
    logic            rsp_ready_i = 1'b0;
    logic [XLEN-1:0] rsp_data_o;
    logic            sram_en_o;
    logic            sram_we_o;
    logic [AW-1:0]   sram_addr_o;
    logic [XLEN-1:0] sram_wdata_o;
    logic [XLEN-1:0] sram_rdata_q;
    logic            flush_i = 1'b0;
    logic            init_done_o;
    logic            seed = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int outstanding = 0;

    logic [XLEN-1:0] sram_mem  [N_ENTRIES];
    logic [XLEN-1:0] model_mem [N_ENTRIES];
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] got_q[$];
    int              acc_cyc_q[$];
    int              got_cyc_q[$];

    always #5 clk_i = ~clk_i;

    sram_req_port #(
        .XLEN      (XLEN),
        .N_ENTRIES (N_ENTRIES),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_data_o   (rsp_data_o),
        .sram_en_o    (sram_en_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_q),
        .flush_i      (flush_i),
        .init_done_o  (init_done_o)
    );

    function automatic logic [XLEN-1:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Single-port SRAM with one-cycle registered read.
    always @(posedge clk_i) begin
        if (seed) begin
            for (int i = 0; i < N_ENTRIES; i++) sram_mem[i] <= init_word(i);
        end else if (sram_en_o) begin
            if (sram_we_o) sram_mem[sram_addr_o] <= sram_wdata_o;
            else           sram_rdata_q <= sram_mem[sram_addr_o];
        end
    end

    // One clock of activity: record what the handshakes did, advance to next negedge.
    task automatic tick();
        #1;
        if (!rst_i) begin
            if (req_valid_i && req_ready_o) begin
                if (req_we_i) begin
                    model_mem[req_addr_i] = req_data_i;
                end else begin
                    exp_q.push_back(model_mem[req_addr_i]);
                    acc_cyc_q.push_back(cyc);
                    outstanding++;
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                got_q.push_back(rsp_data_o);
                got_cyc_q.push_back(cyc);
                outstanding--;
            end
        end
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        acc_cyc_q.delete();
        got_cyc_q.delete();
        outstanding = 0;
    endtask

    task automatic drain(input int n);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 60 && got_q.size() < n; i++) tick();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic run_sweep();
        for (int a = 0; a < N_ENTRIES; a++) begin
            n_checks++;
            if (!(sram_en_o === 1'b1 && sram_we_o === 1'b1 && sram_addr_o === AW'(a) &&
                  sram_wdata_o === '0 && req_ready_o === 1'b0 && init_done_o === 1'b0)) begin
                n_fail++;
                $display("FAIL sweep[%0d]: got en=%b we=%b addr=%0d wdata=%h rdy=%b done=%b, expected en=1 we=1 addr=%0d wdata=0 rdy=0 done=0",
                         a, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o, req_ready_o, init_done_o, a);
            end
            tick();
        end
        n_checks++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_done: init_done_o=%b expected 1", init_done_o);
        end
        for (int i = 0; i < N_ENTRIES; i++) model_mem[i] = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        tick();
        tick();
        n_checks++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || init_done_o !== 1'b0 || rsp_data_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b rsp_valid=%b done=%b rsp_data=%h, expected all 0",
                     req_ready_o, rsp_valid_o, init_done_o, rsp_data_o);
        end
`ifndef SRAM_PORT_INIT_EN
        n_checks++;
        if (sram_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sram_en: got %b expected 0", sram_en_o);
        end
`endif
        rst_i = 1'b0;
        clear_model();
`ifdef SRAM_PORT_INIT_EN
        run_sweep();
`else
        tick();
        n_checks++;
        if (init_done_o !== 1'b1 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: done=%b rdy=%b expected 1 1", init_done_o, req_ready_o);
        end
`endif
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = AW'(5);
        rsp_ready_i = 1'b1;
        tick();
        drain(1);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_read5: got %0d rsp (first %h) expected 1 rsp %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_write_read();
        clear_model();
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = AW'(3);
        req_data_i  = 32'hDEAD_BEEF;
        tick();
        req_we_i = 1'b0;
        tick();
        drain(1);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL raw_data: got %0d rsp (first %h) expected 1 rsp deadbeef",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end else begin
            n_checks++;
            if (got_cyc_q[0] - acc_cyc_q[0] != 2) begin
                n_fail++;
                $display("FAIL raw_latency: got %0d cycles expected 2", got_cyc_q[0] - acc_cyc_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_model();
        rsp_ready_i = 1'b1;
        req_we_i    = 1'b0;
        for (int a = 0; a < 8; a++) begin
            req_valid_i = 1'b1;
            req_addr_i  = AW'(a);
            n_checks++;
            if (req_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", a, req_ready_o);
            end
            tick();
        end
        drain(8);
        n_checks++;
        if (got_q.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 8", got_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || got_cyc_q[i] - acc_cyc_q[i] != 2) begin
                n_fail++;
                $display("FAIL b2b_rsp[%0d]: got %h lat %0d expected %h lat 2",
                         i, got_q[i], got_cyc_q[i] - acc_cyc_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_model();
        rsp_ready_i = 1'b0;
        req_we_i    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = AW'($urandom_range(0, N_ENTRIES - 1));
            tick();
        end
        n_checks++;
        if (outstanding != RSP_DEPTH || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d accepted rdy=%b expected %0d rdy=0",
                     outstanding, req_ready_o, RSP_DEPTH);
        end
        drain(RSP_DEPTH);
        n_checks++;
        if (got_q.size() != RSP_DEPTH) begin
            n_fail++;
            $display("FAIL bp_count: got %0d expected %0d", got_q.size(), RSP_DEPTH);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_model();
        for (int i = 0; i < 300; i++) begin
            req_valid_i = ($urandom % 4) != 0;
            req_we_i    = ($urandom % 3) == 0;
            req_addr_i  = AW'($urandom_range(0, N_ENTRIES - 1));
            req_data_i  = $urandom;
            rsp_ready_i = ($urandom % 4) != 0;
            n_checks++;
            if (req_ready_o !== (outstanding < RSP_DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b expected %b (outstanding %0d)",
                         i, req_ready_o, outstanding < RSP_DEPTH, outstanding);
            end
            tick();
        end
        drain(exp_q.size());
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        rsp_ready_i = 1'b0;
        req_we_i    = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            req_valid_i = 1'b1;
            req_addr_i  = AW'(a);
            tick();
        end
        req_valid_i = 1'b0;
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_outputs: rsp_valid=%b rdy=%b expected 0 0", rsp_valid_o, req_ready_o);
        end
        tick();
        rst_i = 1'b0;
        clear_model();
`ifdef SRAM_PORT_INIT_EN
        run_sweep();
`else
        tick();
`endif
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_restart: rsp_valid=%b rdy=%b expected 0 1", rsp_valid_o, req_ready_o);
        end
        req_valid_i = 1'b1;
        req_addr_i  = AW'(7);
        tick();
        drain(1);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL midrst_read: got %0d rsp (first %h) expected 1 rsp %h",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
    endtask

    task automatic test_flush();
        clear_model();
        rsp_ready_i = 1'b1;
        req_we_i    = 1'b0;
`ifdef SRAM_PORT_INIT_EN
        req_valid_i = 1'b1;
        req_addr_i  = AW'(9);
        tick();
        req_valid_i = 1'b0;
        flush_i     = 1'b1;
        tick();
        n_checks++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pending: init_done_o=%b expected 1", init_done_o);
        end
        tick();
        flush_i = 1'b0;
        run_sweep();
`else
        flush_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid_i = 1'b1;
            req_addr_i  = AW'(i + 8);
            n_checks++;
            if (init_done_o !== 1'b1 || req_ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL flush_ignored[%0d]: done=%b rdy=%b expected 1 1", i, init_done_o, req_ready_o);
            end
            tick();
        end
        flush_i = 1'b0;
`endif
        drain(exp_q.size());
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL flush_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL flush_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N_ENTRIES; i++) model_mem[i] = init_word(i);
        @(negedge clk_i);
        @(negedge clk_i);
        seed = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
